// File: rtl/demuxnx2_pkg.sv
// rtl/demuxnx2_pkg.sv - shared lane state encodings and mode constants for demuxnx2_stream
package demuxnx2_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ONE     = 2'd1,
        FULL    = 2'd2,
        ILLEGAL = 2'd3
    } lane_state_e;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_ALT = 1'b1;

endpackage

// File: rtl/demuxnx2_lane.sv
// rtl/demuxnx2_lane.sv - 2-entry output lane buffer with a registered head word
module demuxnx2_lane
    import demuxnx2_pkg::*;
#(
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [M-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [M-1:0] data
);

    lane_state_e  state_q, state_d;
    logic [M-1:0] head_q, head_d;
    logic [M-1:0] tail_q, tail_d;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = push_data;
                end
            end
            ONE: begin
                // Simultaneous push/pop replaces the head, keeping the lane at one entry.
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    state_d = FULL;
                    tail_d  = push_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign full  = (state_q == FULL);
    assign valid = (state_q == ONE) || (state_q == FULL);
    assign data  = head_q;

endmodule

// File: rtl/demuxnx2_stream.sv
// rtl/demuxnx2_stream.sv - registered 1-to-2 stream demultiplexer, select or alternate routing
module demuxnx2_stream
    import demuxnx2_pkg::*;
#(
    parameter int M = 16
) (
    input  logic         demuxnx2_stream_port_clk,
    input  logic         demuxnx2_stream_port_rst,
    input  logic         demuxnx2_stream_port_mode,
    input  logic [M-1:0] demuxnx2_stream_port_in_data,
    input  logic         demuxnx2_stream_port_in_sel,
    input  logic         demuxnx2_stream_port_in_valid,
    output logic         demuxnx2_stream_port_in_ready,
    output logic [M-1:0] demuxnx2_stream_port_out0_data,
    output logic         demuxnx2_stream_port_out0_valid,
    input  logic         demuxnx2_stream_port_out0_ready,
    output logic [M-1:0] demuxnx2_stream_port_out1_data,
    output logic         demuxnx2_stream_port_out1_valid,
    input  logic         demuxnx2_stream_port_out1_ready,
    output logic         demuxnx2_stream_port_ptr
);

    logic ptr_q, ptr_d;
    logic target;
    logic accept;
    logic push0, push1;
    logic pop0, pop1;
    logic full0, full1;

    // in_ready looks only at the target lane's fill level, never at downstream ready.
    always_comb begin
        target = (demuxnx2_stream_port_mode == MODE_ALT) ? ptr_q : demuxnx2_stream_port_in_sel;
        demuxnx2_stream_port_in_ready = !demuxnx2_stream_port_rst && !(target ? full1 : full0);
        accept = demuxnx2_stream_port_in_valid && demuxnx2_stream_port_in_ready;
        push0  = accept && !target;
        push1  = accept && target;
        ptr_d  = ptr_q;
        if (accept && (demuxnx2_stream_port_mode == MODE_ALT)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge demuxnx2_stream_port_clk) begin
        if (demuxnx2_stream_port_rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pop0 = demuxnx2_stream_port_out0_valid && demuxnx2_stream_port_out0_ready;
    assign pop1 = demuxnx2_stream_port_out1_valid && demuxnx2_stream_port_out1_ready;
    assign demuxnx2_stream_port_ptr = ptr_q;

    demuxnx2_lane #(.M(M)) u_lane0 (
        .clk       (demuxnx2_stream_port_clk),
        .rst       (demuxnx2_stream_port_rst),
        .push      (push0),
        .push_data (demuxnx2_stream_port_in_data),
        .pop       (pop0),
        .full      (full0),
        .valid     (demuxnx2_stream_port_out0_valid),
        .data      (demuxnx2_stream_port_out0_data)
    );

    demuxnx2_lane #(.M(M)) u_lane1 (
        .clk       (demuxnx2_stream_port_clk),
        .rst       (demuxnx2_stream_port_rst),
        .push      (push1),
        .push_data (demuxnx2_stream_port_in_data),
        .pop       (pop1),
        .full      (full1),
        .valid     (demuxnx2_stream_port_out1_valid),
        .data      (demuxnx2_stream_port_out1_data)
    );

endmodule

// File: tb/tb_demuxnx2_stream.sv
// tb/tb_demuxnx2_stream.sv - self-checking bench for demuxnx2_stream with a queue-based lane model
module tb_demuxnx2_stream;

    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [M-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] out0_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [M-1:0] out1_data;
    logic         out1_valid;
    logic         out1_ready;
    logic         ptr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    demuxnx2_stream #(.M(M)) dut (
        .demuxnx2_stream_port_clk        (clk),
        .demuxnx2_stream_port_rst        (rst),
        .demuxnx2_stream_port_mode       (mode),
        .demuxnx2_stream_port_in_data    (in_data),
        .demuxnx2_stream_port_in_sel     (in_sel),
        .demuxnx2_stream_port_in_valid   (in_valid),
        .demuxnx2_stream_port_in_ready   (in_ready),
        .demuxnx2_stream_port_out0_data  (out0_data),
        .demuxnx2_stream_port_out0_valid (out0_valid),
        .demuxnx2_stream_port_out0_ready (out0_ready),
        .demuxnx2_stream_port_out1_data  (out1_data),
        .demuxnx2_stream_port_out1_valid (out1_valid),
        .demuxnx2_stream_port_out1_ready (out1_ready),
        .demuxnx2_stream_port_ptr        (ptr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_sel = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
            n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out0_valid: got %b expected 0", out0_valid); end
            n_checks++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out1_valid: got %b expected 0", out1_valid); end
            n_checks++; if (ptr !== 1'b0) begin n_fail++; $display("FAIL reset_ptr: got %b expected 0", ptr); end
            n_checks++; if (out0_data !== 16'h0) begin n_fail++; $display("FAIL reset_out0_data: got %h expected 0000", out0_data); end
            n_checks++; if (out1_data !== 16'h0) begin n_fail++; $display("FAIL reset_out1_data: got %h expected 0000", out1_data); end
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode0_routing();
        logic [M-1:0] words [3];
        logic         sels  [3];
        words[0] = 16'h1111; sels[0] = 1'b0;
        words[1] = 16'h2222; sels[1] = 1'b1;
        words[2] = 16'h3333; sels[2] = 1'b0;
        mode = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i]; in_sel = sels[i];
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mode0_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            if (sels[i]) begin
                n_checks++; if (out1_valid !== 1'b1 || out1_data !== words[i]) begin n_fail++; $display("FAIL mode0_out1[%0d]: got v=%b d=%h expected v=1 d=%h", i, out1_valid, out1_data, words[i]); end
                n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL mode0_out0_idle[%0d]: got %b expected 0", i, out0_valid); end
            end else begin
                n_checks++; if (out0_valid !== 1'b1 || out0_data !== words[i]) begin n_fail++; $display("FAIL mode0_out0[%0d]: got v=%b d=%h expected v=1 d=%h", i, out0_valid, out0_data, words[i]); end
                n_checks++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL mode0_out1_idle[%0d]: got %b expected 0", i, out1_valid); end
            end
        end
        drain();
    endtask

    task automatic test_alternate();
        logic exp_ptr;
        mode = 1'b1; in_sel = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1;
        exp_ptr = 1'b0;
        n_checks++; if (ptr !== exp_ptr) begin n_fail++; $display("FAIL alt_ptr_start: got %b expected %b", ptr, exp_ptr); end
        for (int i = 0; i < 6; i++) begin
            logic lane;
            lane = exp_ptr;
            in_valid = 1'b1; in_data = 16'hA000 + M'(i);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL alt_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
            exp_ptr = ~exp_ptr;
            n_checks++; if (ptr !== exp_ptr) begin n_fail++; $display("FAIL alt_ptr[%0d]: got %b expected %b", i, ptr, exp_ptr); end
            if (lane) begin
                n_checks++; if (out1_valid !== 1'b1 || out1_data !== (16'hA000 + M'(i))) begin n_fail++; $display("FAIL alt_out1[%0d]: got v=%b d=%h expected v=1 d=%h", i, out1_valid, out1_data, 16'hA000 + M'(i)); end
            end else begin
                n_checks++; if (out0_valid !== 1'b1 || out0_data !== (16'hA000 + M'(i))) begin n_fail++; $display("FAIL alt_out0[%0d]: got v=%b d=%h expected v=1 d=%h", i, out0_valid, out0_data, 16'hA000 + M'(i)); end
            end
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (ptr !== 1'b0) begin n_fail++; $display("FAIL alt_ptr_end: got %b expected 0", ptr); end
        drain();
        mode = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [M-1:0] got [$];
        mode = 1'b0; in_sel = 1'b0; out0_ready = 1'b0; out1_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            in_valid = 1'b1; in_data = M'(i);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept[%0d]: got %b expected 1", i, in_ready); end
            tick();
        end
        in_data = 16'h0003;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
        n_checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h0001) begin n_fail++; $display("FAIL bp_head: got v=%b d=%h expected v=1 d=0001", out0_valid, out0_data); end
        in_valid = 1'b0; in_sel = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_lane1_ready: got %b expected 1", in_ready); end
        in_sel = 1'b0; in_valid = 1'b1;
        tick();
        n_checks++; if (out0_data !== 16'h0001) begin n_fail++; $display("FAIL bp_hold: got %h expected 0001", out0_data); end
        out0_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            logic acc;
            #1;
            if (out0_valid) got.push_back(out0_data);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d expected 3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                n_checks++; if (got[k] !== M'(k + 1)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, got[k], M'(k + 1)); end
            end
        end
        drain();
    endtask

    task automatic test_push_pop_one();
        mode = 1'b0; in_sel = 1'b0; out0_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00AA;
        tick();
        out0_ready = 1'b1; in_data = 16'h00BB;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_before: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (out0_valid !== 1'b1 || out0_data !== 16'h00BB) begin n_fail++; $display("FAIL pp_head: got v=%b d=%h expected v=1 d=00bb", out0_valid, out0_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after: got %b expected 1", in_ready); end
        tick();
        n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL pp_drained: got %b expected 0", out0_valid); end
        drain();
    endtask

    task automatic test_reset_mid();
        mode = 1'b0; in_sel = 1'b1; out1_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0E01; tick();
        in_data = 16'h0E02; tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_full: got %b expected 0", in_ready); end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out1_valid !== 1'b0 || out1_data !== 16'h0) begin n_fail++; $display("FAIL rm_cleared: got v=%b d=%h expected v=0 d=0000", out1_valid, out1_data); end
        out1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale[%0d]: got v=%b d=%h expected v=0", c, out1_valid, out1_data); end
        end
        in_valid = 1'b1; in_data = 16'h5555;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out1_valid !== 1'b1 || out1_data !== 16'h5555) begin n_fail++; $display("FAIL rm_fresh: got v=%b d=%h expected v=1 d=5555", out1_valid, out1_data); end
        drain();
    endtask

    task automatic test_random();
        logic [M-1:0] q0 [$];
        logic [M-1:0] q1 [$];
        logic mp, t, exp_rdy, acc, p0, p1;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0;
        tick();
        rst = 1'b0; mp = 1'b0;
        for (int i = 0; i < 800; i++) begin
            n_checks++; if (out0_valid !== (q0.size() > 0)) begin n_fail++; $display("FAIL rnd_out0_valid[%0d]: got %b expected %b", i, out0_valid, q0.size() > 0); end
            if (q0.size() > 0) begin
                n_checks++; if (out0_data !== q0[0]) begin n_fail++; $display("FAIL rnd_out0_data[%0d]: got %h expected %h", i, out0_data, q0[0]); end
            end
            n_checks++; if (out1_valid !== (q1.size() > 0)) begin n_fail++; $display("FAIL rnd_out1_valid[%0d]: got %b expected %b", i, out1_valid, q1.size() > 0); end
            if (q1.size() > 0) begin
                n_checks++; if (out1_data !== q1[0]) begin n_fail++; $display("FAIL rnd_out1_data[%0d]: got %h expected %h", i, out1_data, q1[0]); end
            end
            n_checks++; if (ptr !== mp) begin n_fail++; $display("FAIL rnd_ptr[%0d]: got %b expected %b", i, ptr, mp); end

            if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 79) == 0);
            in_sel     = 1'($urandom_range(0, 1));
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = M'($urandom);
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            t       = mode ? mp : in_sel;
            exp_rdy = !rst && ((t ? q1.size() : q0.size()) < 2);
            n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy); end
            acc = in_valid && exp_rdy;
            p0  = out0_ready && (q0.size() > 0);
            p1  = out1_ready && (q1.size() > 0);
            tick();
            if (rst) begin
                q0.delete(); q1.delete(); mp = 1'b0;
            end else begin
                if (p0) void'(q0.pop_front());
                if (p1) void'(q1.pop_front());
                if (acc) begin
                    if (t) q1.push_back(in_data);
                    else   q0.push_back(in_data);
                    if (mode) mp = ~mp;
                end
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_mode0_routing();
        test_alternate();
        test_backpressure();
        test_push_pop_one();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demuxnx2_stream.md
# demuxnx2_stream

Registered 1-to-2 stream demultiplexer with valid/ready handshakes, the inverse of the team's M-bit 2:1 mux. It routes each accepted M-bit input word to one of two output lanes, either by a per-word select or by strict alternation. Each lane has a 2-entry buffer so that a stalled lane does not corrupt in-flight data. It sits in front of paired datapaths that are later recombined by the 2:1 mux.

## Interface
- M, 16, data width in bits (≥1)
- demuxnx2_stream_port_clk  in  1  clock; all state updates on rising edge
- demuxnx2_stream_port_rst  in  1  synchronous, active-high reset
- demuxnx2_stream_port_mode  in  1  0 = select-driven, 1 = alternate (lane 0, 1, 0, …)
- demuxnx2_stream_port_in_data  in  M  input word
- demuxnx2_stream_port_in_sel  in  1  target lane in mode 0; ignored in mode 1
- demuxnx2_stream_port_in_valid  in  1  input word present
- demuxnx2_stream_port_in_ready  out  1  block can accept the word this cycle
- demuxnx2_stream_port_out0_data / _out1_data  out  M  lane head word
- demuxnx2_stream_port_out0_valid / _out1_valid  out  1  lane head valid
- demuxnx2_stream_port_out0_ready / _out1_ready  in  1  downstream accepts lane head
- demuxnx2_stream_port_ptr  out  1  next lane in mode 1 (debug/observe)

## Operation
- Target lane t = in_sel (mode 0) or ptr (mode 1).
- in_ready = lane t not FULL. Combinational from mode, in_sel, ptr and the lane state. It does not depend on outN_ready.
- Accept when in_valid & in_ready. The word is pushed into lane t only. The other lane is untouched.
- ptr toggles on every accept while mode = 1. It holds when mode = 0 or when no accept occurs.
- Mode changes take effect in the same cycle. ptr retains its value across mode changes.
- Each lane is a 2-entry FIFO with states EMPTY, ONE and FULL:
  - EMPTY: push → ONE.
  - ONE: push only → FULL. pop only → EMPTY. push and pop together → stays ONE, and the head becomes the pushed word.
  - FULL: pop → ONE, and the second entry becomes the head. A push is impossible because in_ready is low for this lane.
- Pop happens when outN_valid & outN_ready.
- outN_valid = (lane state ≠ EMPTY). outN_data = head entry, driven directly from a register.
- Data is never dropped or reordered within a lane. Order across lanes is not tracked.
- While outN_valid is high and outN_ready is low, outN_data must stay stable.
- in_valid without in_ready: the upstream source holds its word. The block keeps no record of the attempt.

## Timing
- Reset (rst = 1 at an edge): both lanes go EMPTY, ptr = 0, out0_valid = out1_valid = 0, and out0_data = out1_data = 0. Buffer contents are discarded.
- During reset in_ready is forced to 0, and no accept occurs in that cycle.
- Reset asserted mid-transfer discards all buffered words. The first cycle after reset behaves as a fresh start.
- Latency: a word accepted at edge k is visible on outN_data/outN_valid after edge k, i.e. 1 cycle.
- Throughput: one word per cycle sustained, provided the target lane's downstream keeps ready high.
- A lane becomes FULL after two pushes with no pop. in_ready for that lane then drops in the following cycle.
- A pop from FULL re-opens in_ready in the next cycle, not combinationally.
- Output data, valid and ptr are all registered. Only in_ready is combinational.

## Structure
- Shared package demuxnx2_pkg holds:
  - lane state encodings: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2. The value 2'd3 is illegal, and the lane returns to EMPTY if it ever sees it.
  - mode constants: MODE_SEL = 1'b0, MODE_ALT = 1'b1.
- Sub-module demuxnx2_lane #(M): the 2-entry buffer, instantiated twice.
  - Ports: clk, rst, push, push_data, pop, full, valid, data.
- The top level holds the ptr register, target-lane selection, in_ready and push-enable decoding.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 → in_ready = 0, both outN_valid = 0, ptr = 0, outN_data = 0.
- Mode 0 routing: send 0x1111 (sel 0), 0x2222 (sel 1), 0x3333 (sel 0) with both readies high → out0 shows 0x1111 then 0x3333, out1 shows 0x2222, each 1 cycle after acceptance.
- Mode 1 alternation: send 0xA000..0xA005 with in_sel tied to 1 → out0 gets A000, A002, A004 and out1 gets A001, A003, A005; ptr toggles every accept.
- Backpressure: out0_ready = 0, mode 0, sel 0, send 0x0001, 0x0002, 0x0003 → the first two are accepted, in_ready drops, and out0_data holds 0x0001. Then raise out0_ready → output order is 0001, 0002, 0003, with no loss or duplication. Lane 1 with sel 1 remains accepting throughout.
- Simultaneous push/pop in ONE: lane 0 holds 0x00AA and out0_ready = 1 while 0x00BB is pushed → the next cycle shows out0_data = 0x00BB, lane state ONE, in_ready stays 1.
- Reset mid-operation: fill lane 1 to FULL, assert rst for 1 cycle → out1_valid = 0 next cycle, and the old words never appear. A new word 0x5555 then appears 1 cycle after acceptance.
